// File: rtl/ndata_compactor_if.sv
// ndata_i: lane-parallel stream with per-lane keep, end-of-stream last and a
// valid/ready handshake. Lane 0 occupies the least significant slice of data.
interface ndata_i #(
  parameter int NUM_ELEMENTS = 8,
  parameter int DATA_WIDTH   = 64
) ();
  logic [NUM_ELEMENTS-1:0][DATA_WIDTH-1:0] data;
  logic [NUM_ELEMENTS-1:0]                 keep;
  logic                                    last;
  logic                                    valid;
  logic                                    ready;

  modport master (output data, keep, last, valid, input ready);
  modport slave  (input data, keep, last, valid, output ready);
endinterface

// File: rtl/ndata_compactor.sv
// ndata_compactor: packs a sparse lane stream into dense beats whose keep is
// contiguous from lane 0. Elements that do not fill a whole beat are held in a
// residue buffer and prepended to the next input beat. A last beat carrying
// more than one beat's worth of elements is split over two output beats, the
// second being emitted from the FLUSH state while the input is stalled.
// Optional feature macro: NDATA_COMPACTOR_COUNT_EN adds elem_count/count_valid,
// reporting the number of kept elements of each completed stream.
module ndata_compactor #(
  parameter int NUM_ELEMENTS = 8,
  parameter int DATA_WIDTH   = 64
) (
  input  logic   clk,
  input  logic   rst_n,
  ndata_i.slave  in,
  ndata_i.master out
`ifdef NDATA_COMPACTOR_COUNT_EN
  ,
  output logic [31:0] elem_count,
  output logic        count_valid
`endif
);

  // CW bits hold any total c + popcount(keep) <= 2*NUM_ELEMENTS-1
  localparam int CW  = $clog2(2 * NUM_ELEMENTS);
  localparam int CSZ = 1 << CW;
  localparam logic [CW-1:0] NE = CW'(NUM_ELEMENTS);

  typedef logic [DATA_WIDTH-1:0]                   elem_t;
  typedef logic [NUM_ELEMENTS-1:0][DATA_WIDTH-1:0] beat_t;
  typedef enum logic {RUN, FLUSH} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  beat_t                   res_q, res_d;
  beat_t                   data_q, data_d;
  logic [NUM_ELEMENTS-1:0] keep_q, keep_d;
  logic                    last_q, last_d;
  logic                    valid_q, valid_d;

  elem_t                   comb [CSZ];
  logic [CW-1:0]           pos;
  logic [CW-1:0]           total;
  beat_t                   lo_beat, hi_beat;
  logic                    in_ready, accept, out_hs;

  function automatic logic [NUM_ELEMENTS-1:0] low_mask(input logic [CW-1:0] n);
    logic [NUM_ELEMENTS-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < NUM_ELEMENTS; i++) m[i] = (i < 32'(n));
    return m;
  endfunction

  assign in_ready  = (state_q == RUN) && (!valid_q || out.ready);
  assign accept    = in.valid && in_ready;
  assign out_hs    = valid_q && out.ready;

  assign in.ready  = in_ready;
  assign out.data  = data_q;
  assign out.keep  = keep_q;
  assign out.last  = last_q;
  assign out.valid = valid_q;

  // Concatenate residue and kept input lanes into one dense element list.
  // Unused slots stay zero, so any beat sliced from it has zeroed empty lanes.
  always_comb begin
    comb = '{default: '0};
    pos  = cnt_q;
    for (int unsigned k = 0; k < NUM_ELEMENTS; k++)
      if (k < 32'(cnt_q)) comb[k] = res_q[k];
    for (int unsigned l = 0; l < NUM_ELEMENTS; l++)
      if (in.keep[l]) begin
        comb[pos] = in.data[l];
        pos       = pos + CW'(1);
      end
    total = pos;
    for (int unsigned k = 0; k < NUM_ELEMENTS; k++) begin
      lo_beat[k] = comb[k];
      hi_beat[k] = comb[k + NUM_ELEMENTS];
    end
  end

  // Next state for the FSM, residue buffer and output register.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    data_d  = data_q;
    keep_d  = keep_q;
    last_d  = last_q;
    valid_d = valid_q;
    if (out_hs) valid_d = 1'b0;
    case (state_q)
      RUN: begin
        if (accept) begin
          if (!in.last) begin
            if (total < NE) begin
              cnt_d = total;
              res_d = lo_beat;
            end else begin
              valid_d = 1'b1;
              data_d  = lo_beat;
              keep_d  = '1;
              last_d  = 1'b0;
              cnt_d   = total - NE;
              res_d   = hi_beat;
            end
          end else if (total <= NE) begin
            valid_d = 1'b1;
            data_d  = lo_beat;
            keep_d  = low_mask(total);
            last_d  = 1'b1;
            cnt_d   = '0;
            res_d   = '0;
          end else begin
            valid_d = 1'b1;
            data_d  = lo_beat;
            keep_d  = '1;
            last_d  = 1'b0;
            cnt_d   = total - NE;
            res_d   = hi_beat;
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        // Overflow tail is loaded as the full beat leaves; RUN resumes at once
        // and the usual ready gating holds off input until this beat drains.
        if (out_hs) begin
          valid_d = 1'b1;
          data_d  = res_q;
          keep_d  = low_mask(cnt_q);
          last_d  = 1'b1;
          cnt_d   = '0;
          res_d   = '0;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // State, residue and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
      res_q   <= '0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end

`ifdef NDATA_COMPACTOR_COUNT_EN
  logic [31:0] acc_q;
  logic [31:0] elem_count_q;
  logic        count_valid_q;
  logic [31:0] beat_pop;

  // Number of elements in the beat currently on the output.
  always_comb begin
    beat_pop = '0;
    for (int unsigned i = 0; i < NUM_ELEMENTS; i++) beat_pop = beat_pop + 32'(keep_q[i]);
  end

  // Accumulate per stream; publish and pulse when the last beat handshakes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q         <= '0;
      elem_count_q  <= '0;
      count_valid_q <= 1'b0;
    end else begin
      count_valid_q <= 1'b0;
      if (out_hs) begin
        if (last_q) begin
          elem_count_q  <= acc_q + beat_pop;
          acc_q         <= '0;
          count_valid_q <= 1'b1;
        end else begin
          acc_q <= acc_q + beat_pop;
        end
      end
    end
  end

  assign elem_count  = elem_count_q;
  assign count_valid = count_valid_q;
`endif

endmodule

// File: tb/tb_ndata_compactor.sv
// Bench for ndata_compactor (NUM_ELEMENTS=4, DATA_WIDTH=16): directed scenarios
// with literal expectations, then a long random run checked against a
// queue-based element model.
`timescale 1ns/1ps
module tb_ndata_compactor;
  localparam int N  = 4;
  localparam int DW = 16;
  typedef logic [N-1:0][DW-1:0] beat_t;
  typedef struct {
    beat_t        data;
    logic [N-1:0] keep;
    logic         last;
  } obeat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  ndata_i #(.NUM_ELEMENTS(N), .DATA_WIDTH(DW)) in_if ();
  ndata_i #(.NUM_ELEMENTS(N), .DATA_WIDTH(DW)) out_if ();
`ifdef NDATA_COMPACTOR_COUNT_EN
  logic [31:0] elem_count;
  logic        count_valid;
`endif

  ndata_compactor #(.NUM_ELEMENTS(N), .DATA_WIDTH(DW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in(in_if),
    .out(out_if)
`ifdef NDATA_COMPACTOR_COUNT_EN
    ,
    .elem_count(elem_count),
    .count_valid(count_valid)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: flat element queue ----------------
  logic [DW-1:0] pend[$];
  obeat_t        exp_q[$];
  int            beats_seen = 0;
  logic          stall_prev = 1'b0;
  obeat_t        stall_beat;

  task automatic emit(input int n, input logic l);
    obeat_t ob;
    ob.data = '0;
    ob.keep = '0;
    ob.last = l;
    for (int i = 0; i < n; i++) begin
      ob.data[i] = pend.pop_front();
      ob.keep[i] = 1'b1;
    end
    exp_q.push_back(ob);
  endtask

  task automatic model_accept(input beat_t d, input logic [N-1:0] k, input logic l);
    for (int i = 0; i < N; i++) if (k[i]) pend.push_back(d[i]);
    if (!l) begin
      if (pend.size() >= N) emit(N, 1'b0);
    end else begin
      while (pend.size() > N) emit(N, 1'b0);
      emit(pend.size(), 1'b1);
    end
  endtask

  function automatic logic contiguous(input logic [N-1:0] k);
    logic [N:0] kp;
    kp = {1'b0, k} + 1'b1;
    return ((kp[N-1:0] & k) == '0);
  endfunction

  // Compare process: mid-cycle, checks every output handshake against the
  // model, stability under backpressure, and keep contiguity.
  always @(negedge clk) begin
    obeat_t ob;
    if (!rst_n) begin
      pend.delete();
      exp_q.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid", 64'(out_if.valid), 64'd1);
        check("stall_data", out_if.data, stall_beat.data);
        check("stall_keep", 64'(out_if.keep), 64'(stall_beat.keep));
        check("stall_last", 64'(out_if.last), 64'(stall_beat.last));
      end
      if (out_if.valid) begin
        check("keep_contig", 64'(contiguous(out_if.keep)), 64'd1);
        if (out_if.ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_beat: got keep=%0h last=%0b expected no beat (t=%0t)",
                     out_if.keep, out_if.last, $time);
          end else begin
            ob = exp_q.pop_front();
            check("model_data", out_if.data, ob.data);
            check("model_keep", 64'(out_if.keep), 64'(ob.keep));
            check("model_last", 64'(out_if.last), 64'(ob.last));
            beats_seen++;
          end
        end
      end
      stall_prev      = out_if.valid && !out_if.ready;
      stall_beat.data = out_if.data;
      stall_beat.keep = out_if.keep;
      stall_beat.last = out_if.last;
      if (in_if.valid && in_if.ready) model_accept(in_if.data, in_if.keep, in_if.last);
    end
  end

  // ---------------- stimulus ----------------
  logic rand_ready = 1'b0;
  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      out_if.ready = ($urandom_range(3) != 0);
    end
  end

  // Called at posedge+1; returns at posedge+1 of the accepting edge.
  task automatic send(input beat_t d, input logic [N-1:0] k, input logic l);
    int unsigned n;
    n = 0;
    in_if.data  = d;
    in_if.keep  = k;
    in_if.last  = l;
    in_if.valid = 1'b1;
    @(negedge clk);
    while (!in_if.ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!in_if.ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got in.ready=0 for %0d cycles expected accept", n);
    end
    @(posedge clk);
    #1;
    in_if.valid = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    beat_t rd;
    logic  rl;
    int    n;
    in_if.valid  = 1'b0;
    in_if.data   = '0;
    in_if.keep   = '0;
    in_if.last   = 1'b0;
    out_if.ready = 1'b1;
    rst_n        = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 64'(out_if.valid), 64'd0);
    check("rst_keep", 64'(out_if.keep), 64'd0);
    check("rst_last", 64'(out_if.last), 64'd0);
`ifdef NDATA_COMPACTOR_COUNT_EN
    check("rst_count", 64'(elem_count), 64'd0);
    check("rst_cvalid", 64'(count_valid), 64'd0);
`endif
    rst_n = 1'b1;

    // Two sparse beats merge into one dense beat [A,B,C,D]
    send(64'hDEAD_000B_DEAD_000A, 4'b0101, 1'b0);
    check("t1_novalid", 64'(out_if.valid), 64'd0);
    send(64'h000D_DEAD_000C_DEAD, 4'b1010, 1'b0);
    check("t1_valid", 64'(out_if.valid), 64'd1);
    check("t1_data", out_if.data, 64'h000D_000C_000B_000A);
    check("t1_keep", 64'(out_if.keep), 64'hF);
    check("t1_last", 64'(out_if.last), 64'd0);

    // c=3 then a full last beat: full beat, one FLUSH cycle, 3-element tail
    send(64'hDEAD_0010_000F_000E, 4'b0111, 1'b0);
    check("t2_novalid", 64'(out_if.valid), 64'd0);
    send(64'h0014_0013_0012_0011, 4'b1111, 1'b1);
    check("t2_valid", 64'(out_if.valid), 64'd1);
    check("t2_data", out_if.data, 64'h0011_0010_000F_000E);
    check("t2_keep", 64'(out_if.keep), 64'hF);
    check("t2_last", 64'(out_if.last), 64'd0);
    check("t2_flush_rdy", 64'(in_if.ready), 64'd0);
    @(posedge clk); #1;
    check("t2f_data", out_if.data, 64'h0000_0014_0013_0012);
    check("t2f_keep", 64'(out_if.keep), 64'h7);
    check("t2f_last", 64'(out_if.last), 64'd1);
    check("t2f_rdy", 64'(in_if.ready), 64'd1);

    // Empty last beat still emits a boundary beat
    send(64'hFFFF_FFFF_FFFF_FFFF, 4'b0000, 1'b1);
    check("t3_valid", 64'(out_if.valid), 64'd1);
    check("t3_keep", 64'(out_if.keep), 64'd0);
    check("t3_last", 64'(out_if.last), 64'd1);
    check("t3_data", out_if.data, 64'd0);
`ifdef NDATA_COMPACTOR_COUNT_EN
    check("t2_cvalid", 64'(count_valid), 64'd1);
    check("t2_count", 64'(elem_count), 64'd11);
`endif
    @(posedge clk); #1;
    check("t3_idle", 64'(out_if.valid), 64'd0);
`ifdef NDATA_COMPACTOR_COUNT_EN
    check("t3_cvalid", 64'(count_valid), 64'd1);
    check("t3_count", 64'(elem_count), 64'd0);
`endif

    // Backpressure for 5 cycles
    out_if.ready = 1'b0;
    send(64'h0024_0023_0022_0021, 4'b1111, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("t4_valid", 64'(out_if.valid), 64'd1);
      check("t4_data", out_if.data, 64'h0024_0023_0022_0021);
      check("t4_keep", 64'(out_if.keep), 64'hF);
      check("t4_rdy", 64'(in_if.ready), 64'd0);
      @(posedge clk); #1;
    end
    out_if.ready = 1'b1;
    @(posedge clk); #1;
    check("t4_drained", 64'(out_if.valid), 64'd0);
    check("t4_rdy_back", 64'(in_if.ready), 64'd1);
    send(64'h0028_0027_0026_0025, 4'b1111, 1'b1);
    check("t4b_data", out_if.data, 64'h0028_0027_0026_0025);
    check("t4b_last", 64'(out_if.last), 64'd1);

    // Reset mid-stream with c=2 discards the residue
    send(64'hDEAD_DEAD_0032_0031, 4'b0011, 1'b0);
    check("t5_novalid", 64'(out_if.valid), 64'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("t5_rst_valid", 64'(out_if.valid), 64'd0);
    @(posedge clk); #1;
    check("t5_post_valid", 64'(out_if.valid), 64'd0);
    send(64'h0044_0043_0042_0041, 4'b1111, 1'b1);
    check("t5_valid", 64'(out_if.valid), 64'd1);
    check("t5_data", out_if.data, 64'h0044_0043_0042_0041);
    check("t5_keep", 64'(out_if.keep), 64'hF);
    check("t5_last", 64'(out_if.last), 64'd1);
    @(posedge clk); #1;
    check("t5_single", 64'(out_if.valid), 64'd0);
    check("model_beats", 64'(beats_seen), 64'd7);
    check("model_empty", 64'(exp_q.size()), 64'd0);

    // Random keep/last/ready against the model
    rand_ready = 1'b1;
    for (int b = 0; b < 10000; b++) begin
      rd = {$urandom, $urandom};
      rl = (b == 9999) || ($urandom_range(3) == 0);
      send(rd, 4'($urandom_range(15)), rl);
    end
    rand_ready = 1'b0;
    @(posedge clk); #1;
    out_if.ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      n++;
      @(posedge clk); #1;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
    check("end_idle", 64'(out_if.valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
